// File: rtl/btn_pkg.sv
// Shared state encoding and 100 MHz timing defaults for the push-button conditioner.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WQ   = 3'd1,
    SCEN = 3'd2,
    HELD = 3'd3,
    WR   = 3'd4
  } btn_state_e;

  localparam int unsigned DBNC_CYCLES_100MHZ   = 32'd1_000_000;
  localparam int unsigned REPEAT_CYCLES_100MHZ = 32'd25_000_000;

  // Debounced level is asserted from the accepted press until the release is accepted.
  function automatic logic st_pressed(input btn_state_e st);
    st_pressed = (st == SCEN) || (st == HELD) || (st == WR);
  endfunction

endpackage

// File: rtl/btn_debounce_fsm.sv
// Single-button synchronizer, debounce counter and press/repeat FSM.
// Auto-repeat is compiled in only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_fsm
  import btn_pkg::*;
#(
  parameter int unsigned DBNC_CYCLES   = DBNC_CYCLES_100MHZ,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_100MHZ,
  parameter int unsigned CNT_W         = 32'd25
) (
  input  logic ClkPort,
  input  logic Reset_n,
  input  logic btn_raw,
  output logic dpb,
  output logic scen,
  output logic mcen
);

  localparam logic [CNT_W-1:0] DBNC_LAST = CNT_W'(DBNC_CYCLES - 32'd1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 32'd1);
`endif

  if ((DBNC_CYCLES < 32'd2) || (REPEAT_CYCLES < 32'd2) ||
      ((64'd1 << CNT_W) <= 64'(DBNC_CYCLES)) ||
      ((64'd1 << CNT_W) <= 64'(REPEAT_CYCLES))) begin : g_bad_cfg
    $error("btn_debounce_fsm: invalid DBNC_CYCLES/REPEAT_CYCLES/CNT_W");
  end

  logic             s1_r, s2_r;
  btn_state_e       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             rep_s;
  logic             dpb_r, scen_r, mcen_r;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= btn_raw;
      s2_r <= s1_r;
    end
  end

  // Next-state, counter and repeat-pulse decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    rep_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (s2_r) begin
          state_s = WQ;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s   = {CNT_W{1'b0}};
        end
      end
      WQ: begin
        if (!s2_r) begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == DBNC_LAST) begin
          state_s = SCEN;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      SCEN: begin
        state_s = HELD;
        cnt_s   = {CNT_W{1'b0}};
      end
      HELD: begin
        if (!s2_r) begin
          state_s = WR;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          if (cnt_r == REP_LAST) begin
            cnt_s = {CNT_W{1'b0}};
            rep_s = 1'b1;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
`else
          cnt_s = cnt_r;
`endif
        end
      end
      WR: begin
        if (s2_r) begin
          state_s = HELD;
          cnt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == DBNC_LAST) begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State register; outputs are registered from the next state so they share its timing.
  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      dpb_r   <= 1'b0;
      scen_r  <= 1'b0;
      mcen_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      dpb_r   <= st_pressed(state_s);
      scen_r  <= (state_s == SCEN);
      mcen_r  <= (state_s == SCEN) | rep_s;
    end
  end

  assign dpb  = dpb_r;
  assign scen = scen_r;
  assign mcen = mcen_r;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: one independent debounce FSM per button.
// Define BTN_AUTOREPEAT_EN to enable auto-repeat pulses on mcen while held.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN         = 32'd5,
  parameter int unsigned DBNC_CYCLES   = DBNC_CYCLES_100MHZ,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_100MHZ,
  parameter int unsigned CNT_W         = 32'd25
) (
  input  logic             ClkPort,
  input  logic             Reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] dpb,
  output logic [N_BTN-1:0] scen,
  output logic [N_BTN-1:0] mcen
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce_fsm #(
      .DBNC_CYCLES   (DBNC_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .CNT_W         (CNT_W)
    ) u_fsm (
      .ClkPort (ClkPort),
      .Reset_n (Reset_n),
      .btn_raw (btn_raw[i]),
      .dpb     (dpb[i]),
      .scen    (scen[i]),
      .mcen    (mcen[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed table, hand sequences and random stimulus
// compared every cycle against a run-length reference model.
module tb_btn_conditioner;

  localparam int N = 5;
  localparam int D = 8;
  localparam int R = 16;
  localparam int W = 5;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic         ClkPort = 1'b0;
  logic         Reset_n;
  logic [N-1:0] btn_raw;
  logic [N-1:0] dpb, scen, mcen;

  always #5 ClkPort = ~ClkPort;

  btn_conditioner #(.N_BTN(N), .DBNC_CYCLES(D), .REPEAT_CYCLES(R), .CNT_W(W)) dut (
    .ClkPort (ClkPort),
    .Reset_n (Reset_n),
    .btn_raw (btn_raw),
    .dpb     (dpb),
    .scen    (scen),
    .mcen    (mcen)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a press needs D+1 consecutive synchronized high samples, a release
  // D+1 consecutive low samples; the cycle right after an accepted press ignores the input.
  logic [N-1:0] m_s1, m_s2, m_level, m_skip;
  int           m_run [N];
  int           m_held[N];
  logic [N-1:0] e_dpb, e_scen, e_mcen;

  int           cyc, first_scen, scen_hits, mcen_hits, dpb_last;
  logic [N-1:0] first_vec;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_level = '0; m_skip = '0;
    e_dpb = '0; e_scen = '0; e_mcen = '0;
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0;
      m_held[i] = 0;
    end
  endtask

  task automatic model_step(input logic [N-1:0] raw);
    for (int i = 0; i < N; i++) begin
      logic v;
      v = m_s2[i];
      e_scen[i] = 1'b0;
      e_mcen[i] = 1'b0;
      if (m_skip[i]) begin
        m_skip[i] = 1'b0;
        m_run[i]  = 0;
        m_held[i] = 0;
      end else if (v != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == D + 1) begin
          m_run[i]   = 0;
          m_level[i] = ~m_level[i];
          if (m_level[i]) begin
            e_scen[i] = 1'b1;
            e_mcen[i] = 1'b1;
            m_skip[i] = 1'b1;
          end
        end
      end else begin
        if (m_level[i]) begin
          if (m_run[i] > 0) begin
            m_held[i] = 0;
          end else begin
            m_held[i]++;
            if (AR && (m_held[i] % R == 0)) e_mcen[i] = 1'b1;
          end
        end
        m_run[i] = 0;
      end
    end
    m_s2  = m_s1;
    m_s1  = raw;
    e_dpb = m_level;
  endtask

  task automatic check_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic track_reset();
    cyc = 0; first_scen = -1; first_vec = '0;
    scen_hits = 0; mcen_hits = 0; dpb_last = -1;
  endtask

  // One clock: drive, advance model at the edge, sample 1 time unit later.
  task automatic step(input logic [N-1:0] raw);
    btn_raw = raw;
    @(posedge ClkPort);
    model_step(raw);
    #1;
    cyc++;
    check_vec("dpb_model", dpb, e_dpb);
    check_vec("scen_model", scen, e_scen);
    check_vec("mcen_model", mcen, e_mcen);
    if (scen != '0) begin
      if (first_scen < 0) begin
        first_scen = cyc;
        first_vec  = scen;
      end
      scen_hits += $countones(scen);
    end
    mcen_hits += $countones(mcen);
    if (dpb != '0) dpb_last = cyc;
  endtask

  typedef struct {
    logic [N-1:0] mask;
    int           hold;
    int           exp_first;
    logic [N-1:0] exp_vec;
    int           exp_scen;
    int           exp_mcen_ar;
    int           exp_mcen_na;
    int           exp_dpb_last;
  } vec_t;

  vec_t vecs[7];
  logic [N-1:0] rnd;

  initial begin
    vecs[0] = '{5'b00001, 40, 11, 5'b00001, 1, 2, 1, 50};
    vecs[1] = '{5'b00001, 60, 11, 5'b00001, 1, 4, 1, 70};
    vecs[2] = '{5'b00010,  7, -1, 5'b00000, 0, 0, 0, -1};
    vecs[3] = '{5'b00100,  8, -1, 5'b00000, 0, 0, 0, -1};
    vecs[4] = '{5'b00001,  9, 11, 5'b00001, 1, 1, 1, 20};
    vecs[5] = '{5'b10010, 20, 11, 5'b10010, 2, 2, 2, 30};
    vecs[6] = '{5'b11111, 12, 11, 5'b11111, 5, 5, 5, 22};

    Reset_n = 1'b0;
    btn_raw = '1;
    model_reset();
    repeat (3) @(posedge ClkPort);
    #1;
    check_vec("reset_dpb", dpb, 5'b00000);
    check_vec("reset_scen", scen, 5'b00000);
    check_vec("reset_mcen", mcen, 5'b00000);
    btn_raw = '0;
    repeat (2) @(posedge ClkPort);
    #1;
    Reset_n = 1'b1;

    // Directed table: press mask for 'hold' cycles, then observe the aftermath.
    for (int v = 0; v < 7; v++) begin
      track_reset();
      for (int c = 0; c < vecs[v].hold + 40; c++)
        step((c < vecs[v].hold) ? vecs[v].mask : 5'b00000);
      check_int($sformatf("v%0d_first_scen", v), first_scen, vecs[v].exp_first);
      check_vec($sformatf("v%0d_scen_vec", v), first_vec, vecs[v].exp_vec);
      check_int($sformatf("v%0d_scen_hits", v), scen_hits, vecs[v].exp_scen);
      check_int($sformatf("v%0d_mcen_hits", v), mcen_hits,
                AR ? vecs[v].exp_mcen_ar : vecs[v].exp_mcen_na);
      check_int($sformatf("v%0d_dpb_last", v), dpb_last, vecs[v].exp_dpb_last);
    end

    // Bounce on press: 1-0-1-0 every 3 cycles, then a clean hold.
    track_reset();
    for (int c = 0; c < 12; c++) step(((c / 3) % 2 == 0) ? 5'b00001 : 5'b00000);
    repeat (30) step(5'b00001);
    repeat (30) step(5'b00000);
    check_int("bounce_press_first", first_scen, 23);
    check_int("bounce_press_hits", scen_hits, 1);

    // Bounce on release: 5-cycle drop while held must not end the press.
    track_reset();
    repeat (20) step(5'b01000);
    repeat (5)  step(5'b00000);
    repeat (20) step(5'b01000);
    repeat (30) step(5'b00000);
    check_int("bounce_rel_hits", scen_hits, 1);
    check_int("bounce_rel_dpb_last", dpb_last, 55);

    // Reset while held with repeats running, then re-press after release.
    repeat (40) step(5'b00001);
    #2;
    Reset_n = 1'b0;
    #1;
    check_vec("midreset_dpb", dpb, 5'b00000);
    check_vec("midreset_scen", scen, 5'b00000);
    check_vec("midreset_mcen", mcen, 5'b00000);
    model_reset();
    repeat (3) @(posedge ClkPort);
    #1;
    Reset_n = 1'b1;
    track_reset();
    repeat (20) step(5'b00001);
    check_int("midreset_first", first_scen, 11);
    check_int("midreset_hits", scen_hits, 1);
    repeat (30) step(5'b00000);

    // Random toggling: fast chatter first, then slower changes with long holds.
    rnd = '0;
    for (int c = 0; c < 2400; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range((c < 1000) ? 9 : 60, 0) == 0) rnd[i] = ~rnd[i];
      step(rnd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Conditions the raw Nexys4 push-buttons (BtnC/U/D/L/R) before they reach the game logic (block_controller and its FSM). Each button passes through a two-flop synchronizer and a per-button debounce state machine, which produces three outputs:
- a clean level;
- a single-clock enable pulse per press;
- an optional auto-repeat enable pulse while the button is held.

The block sits between the top-level button pins and the movement/selection logic, and runs on the 100 MHz board clock.

## Interface
- `N_BTN`, default 5: number of buttons conditioned.
- `DBNC_CYCLES`, default 1_000_000: stable cycles required to accept a press or release (10 ms at 100 MHz); minimum 2.
- `REPEAT_CYCLES`, default 25_000_000: hold period between auto-repeat pulses (250 ms); minimum 2.
- `CNT_W`, default 25: counter width; must satisfy 2^CNT_W > max(DBNC_CYCLES, REPEAT_CYCLES).

Ports:
- `ClkPort`, in, 1: board clock. One clock only.
- `Reset_n`, in, 1: reset, asynchronous, active-low.
- `btn_raw`, in, N_BTN: raw button pins, asynchronous, active-high.
- `dpb`, out, N_BTN: debounced level.
- `scen`, out, N_BTN: single-clock enable, one pulse per accepted press.
- `mcen`, out, N_BTN: multi-clock enable, which pulses on press and on each repeat.

## Operation
- **Synchronizer.** `btn_raw[i]` is registered into `s1[i]`, then into `s2[i]` (`sync[i]`). Both registers reset to 0.
- **Per-button FSM.** States are IDLE, WQ (wait quiet on press), SCEN, HELD and WR (wait quiet on release). Each button has its own counter `cnt`.
  - IDLE: if `sync`=1, go to WQ with `cnt`←0.
  - WQ: if `sync`=0, go to IDLE. If `cnt`==DBNC_CYCLES-1, go to SCEN. Otherwise `cnt`++.
  - SCEN: lasts exactly one cycle, then go to HELD with `cnt`←0.
  - HELD: if `sync`=0, go to WR with `cnt`←0. Otherwise auto-repeat handling applies (see Configuration).
  - WR: if `sync`=1, go to HELD with `cnt`←0. If `cnt`==DBNC_CYCLES-1, go to IDLE. Otherwise `cnt`++.
- **Outputs.** All outputs are decoded from registered state, so they are glitch-free.
  - `dpb`=1 in SCEN, HELD and WR.
  - `scen`=1 only in SCEN.
  - `mcen`=1 in SCEN and in the one-cycle repeat pulse.
- **Independence.** Buttons are fully independent. Simultaneous presses produce simultaneous, independent pulses. No priority is applied.
- **Bounce.** Any bounce shorter than DBNC_CYCLES during WQ returns the FSM to IDLE with no pulse. Any bounce during WR returns it to HELD with no second `scen`.
- **Counter saturation.** The counter never wraps. Every compare is an equality test against a constant below 2^CNT_W, and `cnt` is cleared on every state change.

## Timing
- **Reset.** All outputs are 0, all FSMs are in IDLE, and `s1`/`s2`/`cnt` are 0. Reset takes effect immediately on `Reset_n` falling, including mid-press and mid-repeat. Release of `Reset_n` is synchronous to `ClkPort` via a reset synchronizer upstream. After release, a button that is still held is treated as a new press.
- **Press latency.** With `btn_raw` held high from before edge 1:
  - `sync` is 1 after edge 2;
  - the FSM enters WQ at edge 3;
  - it enters SCEN at edge DBNC_CYCLES+3;
  - `scen`/`mcen`/`dpb` are high in the cycle after that edge.
- **Release latency.** `dpb` falls DBNC_CYCLES+3 edges after `btn_raw` falls cleanly.
- **Pulse width.** `scen` is exactly one cycle per accepted press, regardless of how long the button is held.

## Configuration
- `BTN_AUTOREPEAT_EN` defined:
  - in HELD, `cnt` increments each cycle;
  - when `cnt`==REPEAT_CYCLES-1, `mcen` pulses for one cycle and `cnt`←0;
  - the first repeat follows the SCEN pulse by REPEAT_CYCLES+1 cycles, and later repeats follow every REPEAT_CYCLES cycles while the button is held.
- `BTN_AUTOREPEAT_EN` undefined:
  - HELD does not count;
  - `mcen` is identical to `scen`;
  - the repeat compare logic is not synthesized.

## Structure
- **Shared package `btn_pkg`:** the state encoding constants (IDLE, WQ, SCEN, HELD, WR; 3-bit, one-hot is not required) and the default DBNC/REPEAT cycle constants for 100 MHz.
- **Sub-module `btn_debounce_fsm`:** one instance per button, containing the synchronizer, counter and FSM. `btn_conditioner` is a generate loop over N_BTN instances.

## Test plan
All scenarios use DBNC_CYCLES=8 and REPEAT_CYCLES=16.
- **Clean press.** Raise `btn_raw[0]` for 40 cycles → `scen[0]` is a single pulse at cycle 11 after the rise, and `dpb[0]` stays high until 11 cycles after the fall.
- **Bounce on press.** Apply 1-0-1-0 toggles every 3 cycles, then hold high → exactly one `scen`, 11 cycles after the final rise. Glitches shorter than 8 cycles → no pulse at all.
- **Bounce on release.** Drop the input for 5 cycles, then restore it while HELD → `dpb` stays 1 and there is no second `scen`.
- **Auto-repeat.** With `BTN_AUTOREPEAT_EN` defined, hold for 60 cycles → `mcen` pulses at the `scen` cycle and then 17, 33 and 49 cycles later. Without the macro → only one `mcen` pulse, coincident with `scen`.
- **Simultaneous presses.** Raise `btn_raw[1]` and `btn_raw[4]` on the same cycle → `scen[1]` and `scen[4]` pulse in the same cycle, and all other bits stay 0.
- **Reset mid-operation.** Assert `Reset_n`=0 while in HELD with auto-repeat running → all outputs go to 0 immediately. After release with the button still held → a new `scen` appears 11 cycles later.
